// File: rtl/int_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Optional signed support is enabled by defining INT_DIV_SIGNED_EN.
package int_div_pkg;

  localparam int unsigned DIV_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Quotient reported for a zero divisor at the default width
  localparam logic [DIV_DATA_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

  // Bits needed to count 0..v-1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/int_seq_divider_if.sv
// Operand/result valid-ready bundle between the ALU op decoder and the divider.
// The signed_in wire only matters when INT_DIV_SIGNED_EN is defined.
interface int_seq_divider_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  signed_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, signed_in, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, signed_in, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/int_borrow_subtractor.sv
// Ripple borrow-chain subtractor: o_difference = i_minuend - i_subtrahend - i_borrow.
// The subtract counterpart of the carry-chain adder used by the multiplier.
module int_borrow_subtractor #(
  parameter int unsigned WIDTH = 33
) (
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  input  logic             i_borrow,
  output logic [WIDTH-1:0] o_difference,
  output logic             o_borrow
);

  logic [WIDTH:0] w_b;

  assign w_b[0] = i_borrow;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_difference[i] = i_minuend[i] ^ i_subtrahend[i] ^ w_b[i];
    assign w_b[i+1]        = (~i_minuend[i] & i_subtrahend[i]) |
                             (~(i_minuend[i] ^ i_subtrahend[i]) & w_b[i]);
  end

  assign o_borrow = w_b[WIDTH];

endmodule

// File: rtl/int_seq_divider.sv
// Multi-cycle restoring divider retiring one quotient bit per clock.
// Define INT_DIV_SIGNED_EN to add two's-complement operation selected by signed_in.
module int_seq_divider
  import int_div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  int_seq_divider_if.slave   bus
);

  localparam int unsigned CW = clog2(DATA_WIDTH);

  div_state_e            r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_dvd;
  logic [DATA_WIDTH-1:0] r_dsr;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_q;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_quotient;
  logic [DATA_WIDTH-1:0] r_remainder;
  logic                  r_dz;

  logic [DATA_WIDTH:0]   w_p;
  logic [DATA_WIDTH:0]   w_d;
  logic                  w_borrow;
  logic [DATA_WIDTH-1:0] w_rem_next;
  logic [DATA_WIDTH-1:0] w_q_next;
  logic [DATA_WIDTH-1:0] w_dvd_mag;
  logic [DATA_WIDTH-1:0] w_dsr_mag;
  logic [DATA_WIDTH-1:0] w_q_fix;
  logic [DATA_WIDTH-1:0] w_r_fix;
  logic                  w_unused;

  // One restoring step: trial-subtract divisor from the shifted partial remainder
  assign w_p = {r_rem, r_dvd[DATA_WIDTH-1]};

  int_borrow_subtractor #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_sub (
    .i_minuend    (w_p),
    .i_subtrahend ({1'b0, r_dsr}),
    .i_borrow     (1'b0),
    .o_difference (w_d),
    .o_borrow     (w_borrow)
  );

  assign w_rem_next = w_borrow ? w_p[DATA_WIDTH-1:0] : w_d[DATA_WIDTH-1:0];
  assign w_q_next   = {r_q[DATA_WIDTH-2:0], ~w_borrow};

`ifdef INT_DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_dvd_neg;
  logic w_dsr_neg;

  // Magnitudes on accept; sign fixup folded into the final step's result load
  always_comb begin
    w_dvd_neg = bus.signed_in & bus.dividend[DATA_WIDTH-1];
    w_dsr_neg = bus.signed_in & bus.divisor[DATA_WIDTH-1];
    w_dvd_mag = w_dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    w_dsr_mag = w_dsr_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    w_q_fix   = r_neg_q ? (~w_q_next + 1'b1) : w_q_next;
    w_r_fix   = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == DIV_IDLE && bus.in_valid) begin
      r_neg_q <= w_dvd_neg ^ w_dsr_neg;
      r_neg_r <= w_dvd_neg;
    end
  end
`else
  always_comb begin
    w_dvd_mag = bus.dividend;
    w_dsr_mag = bus.divisor;
    w_q_fix   = w_q_next;
    w_r_fix   = w_rem_next;
  end
`endif

  assign w_unused = &{1'b0, w_d[DATA_WIDTH], bus.signed_in};

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= DIV_IDLE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dz        <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (bus.in_valid) begin
            r_dvd      <= w_dvd_mag;
            r_dsr      <= w_dsr_mag;
            r_rem      <= '0;
            r_q        <= '0;
            r_in_ready <= 1'b0;
            if (bus.divisor == '0) begin
              // Zero divisor skips the datapath; out_valid follows one edge later
              r_quotient  <= '1;
              r_remainder <= bus.dividend;
              r_dz        <= 1'b1;
              r_state     <= DIV_DONE;
            end else begin
              r_cnt   <= CW'(DATA_WIDTH - 1);
              r_state <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_dvd <= {r_dvd[DATA_WIDTH-2:0], 1'b0};
          if (r_cnt == '0) begin
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
            r_dz        <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DIV_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DIV_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= DIV_IDLE;
          end
        end
        default: begin
          r_state     <= DIV_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dz;

endmodule

// File: tb/tb_int_seq_divider.sv
// Directed bench for int_seq_divider at DATA_WIDTH=32 with hand-computed results.
// Signed vectors are exercised when INT_DIV_SIGNED_EN is defined.
module tb_int_seq_divider;

  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  int_seq_divider_if #(.DATA_WIDTH(W)) bus ();

  int_seq_divider #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Accept one operation and wait for out_valid; returns edges counted from the accept edge (=1)
  task automatic start_and_wait(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dsr,
                                input logic sgn, output int lat);
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.dividend  = dvd;
    bus.divisor   = dsr;
    bus.signed_in = sgn;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_timeout"}, 64'(bus.out_valid), 64'd1);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_back_idle"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_ov_low"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dsr,
                         input logic sgn, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int elat);
    int lat;
    start_and_wait(tag, dvd, dsr, sgn, lat);
    if (elat != 0) check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_q"}, 64'(bus.quotient), 64'(eq));
    check({tag, "_r"}, 64'(bus.remainder), 64'(er));
    check({tag, "_dz"}, 64'(bus.div_by_zero), 64'(edz));
    release_result(tag);
  endtask

  initial begin
    int lat;
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.signed_in = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_q", 64'(bus.quotient), 64'd0);
    check("rst_r", 64'(bus.remainder), 64'd0);
    check("rst_dz", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b0;

    run_div("d100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2, 1'b0, 33);
    run_div("d5_0",     32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5, 1'b1, 2);
    run_div("dmax_1",   32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0, 1'b0, 33);
    run_div("d3_min",   32'd3,          32'h8000_0000,  1'b0, 32'd0,          32'd3, 1'b0, 33);
    run_div("d0_5",     32'd0,          32'd5,          1'b0, 32'd0,          32'd0, 1'b0, 0);
    run_div("d1e6_1e3", 32'd1000000,    32'd1000,       1'b0, 32'd1000,       32'd0, 1'b0, 0);
    run_div("dmin_3",   32'h8000_0000,  32'd3,          1'b0, 32'd715827882,  32'd2, 1'b0, 0);
    run_div("dneg7_2u", 32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1, 1'b0, 0);

    // Result held under back-pressure; new operands ignored while busy
    start_and_wait("hold", 32'd100, 32'd7, 1'b0, lat);
    bus.in_valid = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_q", 64'(bus.quotient), 64'd14);
      check("hold_r", 64'(bus.remainder), 64'd2);
      check("hold_ov", 64'(bus.out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    release_result("hold");
    check("hold_no_new_op_q", 64'(bus.quotient), 64'd14);

    // Reset during the 10th CALC cycle aborts the operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("abort_busy", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_q", 64'(bus.quotient), 64'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_no_result", 64'(bus.out_valid), 64'd0);
    run_div("d9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33);

`ifdef INT_DIV_SIGNED_EN
    run_div("s_neg7_2",  32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_div("s_min_m1",  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0, 33);
    run_div("s_7_neg2",  32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0, 0);
    run_div("s_neg7_0",  32'hFFFF_FFF9, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 2);
`else
    run_div("u_sgn_ign", 32'hFFFF_FFF9, 32'd2,         1'b1, 32'h7FFF_FFFC, 32'd1,         1'b0, 33);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
